led_sequencer: RTL and testbench



---
 rtl/led_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_led_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
`timescale 1ns / 1ps
// led_sequencer: Avalon-MM slave pattern engine for the board LED bank.
//
// A programmable prescaler produces step pulses; each step advances the LED
// pattern according to the selected mode (static, rotate-left, bounce, blink).
// Completing a sequence sets a sticky wrap flag that can raise an interrupt.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    register select (0 DATA, 1 CTRL, 2 PERIOD, 3 STATUS)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   read data, combinational, zero-extended
//   out_port   LED drive
//   irq        level interrupt, wrap_flag & ien
module led_sequencer #(
    parameter int unsigned             WIDTH        = 10,
    parameter int unsigned             DIV_WIDTH    = 24,
    parameter logic [DIV_WIDTH-1:0]    RESET_PERIOD = DIV_WIDTH'(4999999)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int unsigned        IdxW    = $clog2(WIDTH);
    localparam logic [IdxW-1:0]    IdxLast = IdxW'(WIDTH - 1);

    localparam logic [1:0] AddrData   = 2'd0;
    localparam logic [1:0] AddrCtrl   = 2'd1;
    localparam logic [1:0] AddrPeriod = 2'd2;
    localparam logic [1:0] AddrStatus = 2'd3;

    typedef enum logic [1:0] {
        ModeStatic = 2'd0,
        ModeRotate = 2'd1,
        ModeBounce = 2'd2,
        ModeBlink  = 2'd3
    } mode_e;

    // Architectural state
    logic [WIDTH-1:0]     pattern_q, pattern_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 run_q, run_d;
    mode_e                mode_q, mode_d;
    logic                 ien_q, ien_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 dir_q, dir_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 phase_q, phase_d;
    logic                 wrap_q, wrap_d;

    logic wr_en;
    logic restart;
    logic step;
    logic unused_wdata;

    assign wr_en   = chipselect & ~write_n;
    // Writes to DATA, CTRL and PERIOD restart the sequence; STATUS does not.
    assign restart = wr_en & (address != AddrStatus);

    // Only the low bits of writedata reach storage.
    assign unused_wdata = ^writedata;

    // Prescaler tick: one step every PERIOD+1 cycles while running.
    always_comb begin
        step = run_q && (cnt_q == period_q);
    end

    // Next-state logic
    always_comb begin
        pattern_d = pattern_q;
        out_d     = out_q;
        run_d     = run_q;
        mode_d    = mode_q;
        ien_d     = ien_q;
        period_d  = period_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        wrap_d    = wrap_q;

        if (!run_q || step) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Clear first so that a wrap set later in this block takes priority.
        if (wr_en && (address == AddrStatus) && writedata[0]) begin
            wrap_d = 1'b0;
        end

        if (restart) begin
            // A restart discards any coincident step.
            cnt_d   = '0;
            dir_d   = 1'b0;
            idx_d   = '0;
            phase_d = 1'b0;
            unique case (address)
                AddrData: begin
                    pattern_d = writedata[WIDTH-1:0];
                    out_d     = writedata[WIDTH-1:0];
                end
                AddrCtrl: begin
                    run_d  = writedata[0];
                    mode_d = mode_e'(writedata[2:1]);
                    ien_d  = writedata[3];
                    // Stopping leaves the LEDs frozen where they are.
                    if (writedata[0]) begin
                        out_d = pattern_q;
                    end
                end
                AddrPeriod: begin
                    period_d = writedata[DIV_WIDTH-1:0];
                    out_d    = pattern_q;
                end
                default: ;
            endcase
        end else if (step) begin
            unique case (mode_q)
                ModeStatic: ;
                ModeRotate: begin
                    out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                    if (idx_q == IdxLast) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ModeBounce: begin
                    // Reversal happens on the step that would shift a lit bit out.
                    if (!dir_q) begin
                        if (out_q[WIDTH-1]) begin
                            dir_d = 1'b1;
                            out_d = out_q >> 1;
                        end else begin
                            out_d = out_q << 1;
                        end
                    end else begin
                        if (out_q[0]) begin
                            dir_d  = 1'b0;
                            out_d  = out_q << 1;
                            wrap_d = 1'b1;
                        end else begin
                            out_d = out_q >> 1;
                        end
                    end
                end
                ModeBlink: begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        out_d = '0;
                    end else begin
                        out_d  = pattern_q;
                        wrap_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= '0;
            out_q     <= '0;
            run_q     <= 1'b0;
            mode_q    <= ModeStatic;
            ien_q     <= 1'b0;
            period_q  <= RESET_PERIOD;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            idx_q     <= '0;
            phase_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            out_q     <= out_d;
            run_q     <= run_d;
            mode_q    <= mode_d;
            ien_q     <= ien_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            wrap_q    <= wrap_d;
        end
    end

    // Read mux, zero latency
    always_comb begin
        readdata = '0;
        unique case (address)
            AddrData:   readdata = 32'(out_q);
            AddrCtrl:   readdata = {28'b0, ien_q, mode_q, run_q};
            AddrPeriod: readdata = 32'(period_q);
            AddrStatus: readdata = {31'b0, wrap_q};
            default:    readdata = '0;
        endcase
    end

    assign out_port = out_q;
    assign irq      = wrap_q & ien_q;

endmodule

// File: tb/tb_led_sequencer.sv
`timescale 1ns / 1ps
module tb_led_sequencer;

    localparam int unsigned WIDTH = 10;

    logic             clk        = 1'b0;
    logic             reset      = 1'b1;
    logic [1:0]       address    = 2'd0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = 32'd0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             irq;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    led_sequencer #(
        .WIDTH       (WIDTH),
        .DIV_WIDTH   (24),
        .RESET_PERIOD(24'd4999999)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write lands on the next posedge; returns at the following negedge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        #1;
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset and readback
        cycles(2);
        reset = 1'b0;
        check("rst_out", 32'(out_port), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rd_check("rst_ctrl", 2'd1, 32'h0);
        rd_check("rst_period", 2'd2, 32'h004C_4B3F);
        rd_check("rst_status", 2'd3, 32'h0);

        wr(2'd2, 32'd3);
        wr(2'd1, 32'h3);
        wr(2'd0, 32'h001);
        check("rb_out", 32'(out_port), 32'h001);
        rd_check("rb_ctrl", 2'd1, 32'h3);
        rd_check("rb_period", 2'd2, 32'd3);
        rd_check("rb_data", 2'd0, 32'h001);
        rd_check("rb_status", 2'd3, 32'h0);

        // Rotate, PERIOD=3
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h001);
        wr(2'd1, 32'h3);
        cycles(3);
        check("rot_pre", 32'(out_port), 32'h001);
        cycles(1);
        check("rot_4", 32'(out_port), 32'h002);
        cycles(4);
        check("rot_8", 32'(out_port), 32'h004);
        cycles(31);
        check("rot_39", 32'(out_port), 32'h200);
        rd_check("rot_39_status", 2'd3, 32'h0);
        cycles(1);
        check("rot_40", 32'(out_port), 32'h001);
        rd_check("rot_40_status", 2'd3, 32'h1);
        check("rot_40_irq", 32'(irq), 32'h0);
        wr(2'd1, 32'hB);
        check("rot_ien_irq", 32'(irq), 32'h1);
        check("rot_ien_out", 32'(out_port), 32'h001);
        wr(2'd3, 32'h1);
        check("rot_w1c_irq", 32'(irq), 32'h0);
        rd_check("rot_w1c_status", 2'd3, 32'h0);

        // Bounce, PERIOD=0
        wr(2'd1, 32'h0);
        wr(2'd3, 32'h1);
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h200);
        wr(2'd1, 32'hD);
        check("bnc_start", 32'(out_port), 32'h200);
        for (int k = 1; k <= 9; k++) begin
            cycles(1);
            check($sformatf("bnc_%0d", k), 32'(out_port), 32'h200 >> k);
        end
        check("bnc_irq_pre", 32'(irq), 32'h0);
        cycles(1);
        check("bnc_wrap_out", 32'(out_port), 32'h002);
        check("bnc_wrap_irq", 32'(irq), 32'h1);
        rd_check("bnc_wrap_status", 2'd3, 32'h1);

        // Blink, PERIOD=1
        wr(2'd1, 32'h0);
        wr(2'd3, 32'h1);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'h155);
        wr(2'd1, 32'h7);
        cycles(1);
        check("blk_1", 32'(out_port), 32'h155);
        cycles(1);
        check("blk_2", 32'(out_port), 32'h000);
        cycles(1);
        check("blk_3", 32'(out_port), 32'h000);
        rd_check("blk_3_status", 2'd3, 32'h0);
        cycles(1);
        check("blk_4", 32'(out_port), 32'h155);
        rd_check("blk_4_status", 2'd3, 32'h1);
        check("blk_4_irq", 32'(irq), 32'h0);
        cycles(2);
        check("blk_6", 32'(out_port), 32'h000);

        // DATA write on a step edge: restart wins
        cycles(1);
        wr(2'd0, 32'h3FF);
        check("col_data", 32'(out_port), 32'h3FF);
        cycles(1);
        check("col_hold", 32'(out_port), 32'h3FF);
        cycles(1);
        check("col_step", 32'(out_port), 32'h000);
        wr(2'd3, 32'h1);
        rd_check("col_clr", 2'd3, 32'h0);
        // W1C on the wrap edge: set wins
        wr(2'd3, 32'h1);
        rd_check("col_w1c_set", 2'd3, 32'h1);
        check("col_w1c_out", 32'(out_port), 32'h3FF);

        // Reset mid-run with a concurrent write
        wr(2'd1, 32'h0);
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h001);
        wr(2'd1, 32'h3);
        cycles(6);
        check("mr_pre", 32'(out_port), 32'h040);
        reset = 1'b1;
        wr(2'd0, 32'h3FF);
        reset = 1'b0;
        check("mr_out", 32'(out_port), 32'h0);
        check("mr_irq", 32'(irq), 32'h0);
        rd_check("mr_ctrl", 2'd1, 32'h0);
        rd_check("mr_period", 2'd2, 32'h004C_4B3F);
        rd_check("mr_status", 2'd3, 32'h0);
        cycles(10);
        check("mr_idle", 32'(out_port), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
